// File: rtl/ball_draw.sv
// Repaints the ball square in the VGA framebuffer: erases the previous square
// in background colour, then draws the new one, one registered pixel per cycle.
module ball_draw #(
    parameter int          BALL_SIZE   = 4,
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter logic [2:0]  BALL_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        upd_valid,
    output logic        upd_ready,
    output logic [9:0]  x_out,
    output logic [9:0]  y_out,
    output logic [2:0]  colour_out,
    output logic        plot,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAST = 4'(BALL_SIZE - 1);

    // Sum is one bit wider than the coordinate so off-screen carries are visible to the clip test.
    function automatic logic [10:0] pix_sum(input logic [9:0] base, input logic [3:0] off);
        return {1'b0, base} + {7'd0, off};
    endfunction

    function automatic logic on_screen(input logic [10:0] sx, input logic [10:0] sy);
        return (sx < 11'(SCREEN_W)) && (sy < 11'(SCREEN_H));
    endfunction

    logic [1:0]  state, state_n;
    logic [3:0]  dx, dy, dx_n, dy_n;
    logic [9:0]  new_x, new_y, old_x, old_y;
    logic        have_old;

    logic        accept;
    logic        finish;
    logic        load;
    logic        last;
    logic [9:0]  pbx, pby;
    logic [2:0]  pcol;
    logic [10:0] sum_x, sum_y;

    assign accept = (state == S_IDLE) && upd_valid;
    assign last   = (dx == LAST) && (dy == LAST);
    assign sum_x  = pix_sum(pbx, dx_n);
    assign sum_y  = pix_sum(pby, dy_n);

    // Decide the pixel to present next cycle; outputs are then registered from it.
    always_comb begin
        state_n = state;
        dx_n    = dx;
        dy_n    = dy;
        load    = 1'b0;
        finish  = 1'b0;
        pbx     = new_x;
        pby     = new_y;
        pcol    = BALL_COLOUR;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    dx_n = 4'd0;
                    dy_n = 4'd0;
                    load = 1'b1;
                    if (have_old) begin
                        state_n = S_ERASE;
                        pbx     = old_x;
                        pby     = old_y;
                        pcol    = BG_COLOUR;
                    end else begin
                        state_n = S_DRAW;
                        pbx     = pos_x;
                        pby     = pos_y;
                    end
                end
            end
            S_ERASE: begin
                load = 1'b1;
                if (last) begin
                    state_n = S_DRAW;
                    dx_n    = 4'd0;
                    dy_n    = 4'd0;
                end else begin
                    pbx  = old_x;
                    pby  = old_y;
                    pcol = BG_COLOUR;
                    if (dx == LAST) begin
                        dx_n = 4'd0;
                        dy_n = dy + 4'd1;
                    end else begin
                        dx_n = dx + 4'd1;
                    end
                end
            end
            S_DRAW: begin
                if (last) begin
                    state_n = S_DONE;
                    finish  = 1'b1;
                end else begin
                    load = 1'b1;
                    if (dx == LAST) begin
                        dx_n = 4'd0;
                        dy_n = dy + 4'd1;
                    end else begin
                        dx_n = dx + 4'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            dx         <= 4'd0;
            dy         <= 4'd0;
            new_x      <= 10'd0;
            new_y      <= 10'd0;
            old_x      <= 10'd0;
            old_y      <= 10'd0;
            have_old   <= 1'b0;
            upd_ready  <= 1'b1;
            plot       <= 1'b0;
            done       <= 1'b0;
            x_out      <= 10'd0;
            y_out      <= 10'd0;
            colour_out <= 3'd0;
        end else begin
            state     <= state_n;
            dx        <= dx_n;
            dy        <= dy_n;
            upd_ready <= (state_n == S_IDLE);
            done      <= (state_n == S_DONE);
            plot      <= load && on_screen(sum_x, sum_y);
            if (accept) begin
                new_x <= pos_x;
                new_y <= pos_y;
            end
            if (finish) begin
                old_x    <= new_x;
                old_y    <= new_y;
                have_old <= 1'b1;
            end
            if (load) begin
                x_out      <= sum_x[9:0];
                y_out      <= sum_y[9:0];
                colour_out <= pcol;
            end
        end
    end

endmodule

// File: tb/tb_ball_draw.sv
// Scoreboard bench for ball_draw: stimulus pushes expected plot/done events
// with their cycle numbers, a monitor pops and compares on every plot or done.
module tb_ball_draw;

    localparam int BS = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [9:0]  pos_x = 10'd0;
    logic [9:0]  pos_y = 10'd0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [9:0]  x_out, y_out;
    logic [2:0]  colour_out;
    logic        plot, done;

    ball_draw dut (
        .clk        (clk),
        .resetn     (resetn),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    bit   m_have_old = 1'b0;
    int   m_ox = 0;
    int   m_oy = 0;

    // Monitor: every plot or done must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && (plot || done)) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out cyc=%0d plot=%0b done=%0b x=%0d y=%0d c=%0d",
                         cyc, plot, done, x_out, y_out, colour_out);
            end else begin
                e = sb.pop_front();
                if (e.is_done != done || e.is_done == plot || e.cyc != cyc ||
                    (!e.is_done && (x_out != e.x || y_out != e.y || colour_out != e.c))) begin
                    n_err++;
                    $display("FAIL pixel got cyc=%0d done=%0b x=%0d y=%0d c=%0d, expected cyc=%0d done=%0b x=%0d y=%0d c=%0d",
                             cyc, done, x_out, y_out, colour_out, e.cyc, e.is_done, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d (cyc=%0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_pix(input int c, input int x, input int y, input logic [2:0] col);
        exp_t e;
        if (x < 160 && y < 120) begin
            e.is_done = 1'b0;
            e.cyc = c;
            e.x = 10'(x);
            e.y = 10'(y);
            e.c = col;
            sb.push_back(e);
        end
    endtask

    // Expected plots/done for one accepted update; returns the erase length in cycles.
    task automatic push_update(input int acc, input int nx, input int ny, output int off);
        exp_t e;
        off = 0;
        if (m_have_old) begin
            for (int k = 0; k < BS*BS; k++)
                push_pix(acc + k, m_ox + k % BS, m_oy + k / BS, 3'b000);
            off = BS*BS;
        end
        for (int k = 0; k < BS*BS; k++)
            push_pix(acc + off + k, nx + k % BS, ny + k / BS, 3'b111);
        e.is_done = 1'b1;
        e.cyc = acc + off + BS*BS;
        e.x = 10'd0;
        e.y = 10'd0;
        e.c = 3'd0;
        sb.push_back(e);
        m_have_old = 1'b1;
        m_ox = nx;
        m_oy = ny;
    endtask

    task automatic do_update(input int px, input int py, input bit hold,
                             input bit wait_done, output int acc);
        int n = 0;
        int off;
        int lat;
        while (!upd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", int'(upd_ready), 1);
        pos_x = 10'(px);
        pos_y = 10'(py);
        upd_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) upd_valid = 1'b0;
        push_update(acc, px, py, off);
        if (wait_done) begin
            lat = off + BS*BS + 2;
            do begin
                @(negedge clk);
                if (hold) begin
                    pos_x = 10'($urandom_range(0, 150));
                    pos_y = 10'($urandom_range(0, 110));
                end
                if (cyc == acc + lat - 2) check("ready_low_in_done", int'(upd_ready), 0);
            end while (cyc < acc + lat - 1);
            check("ready_after_done", int'(upd_ready), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        #3 resetn = 1'b0;
        #20;
        check("rst_upd_ready", int'(upd_ready), 1);
        check("rst_plot", int'(plot), 0);
        check("rst_done", int'(done), 0);
        check("rst_x_out", int'(x_out), 0);
        check("rst_y_out", int'(y_out), 0);
        check("rst_colour", int'(colour_out), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        do_update(10, 20, 1'b0, 1'b1, acc);   // first draw, no erase
        do_update(11, 21, 1'b0, 1'b1, acc);   // erase + draw
        do_update(10, 20, 1'b0, 1'b1, acc);
        do_update(10, 20, 1'b0, 1'b1, acc);   // same position twice
        do_update(158, 118, 1'b0, 1'b1, acc); // clipped corner
        do_update(20, 30, 1'b1, 1'b1, acc);   // valid held, pos scrambled during repaint
        do_update(40, 50, 1'b0, 1'b1, acc);

        // Reset during draw pixel 5 (after 16 erase cycles)
        do_update(30, 40, 1'b0, 1'b0, acc);
        while (cyc < acc + BS*BS + 4) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_plot", int'(plot), 0);
        check("midrst_ready", int'(upd_ready), 1);
        check("midrst_done", int'(done), 0);
        sb.delete();
        m_have_old = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        do_update(60, 70, 1'b0, 1'b1, acc);   // draw only after reset

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
